// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: command sequencer that drives one universal shift register (USR).
// Optional abort support is enabled by defining USR_SEQ_CTRL_ABORT_EN.
module usr_seq_ctrl #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [SIZE-1:0]  cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
`ifdef USR_SEQ_CTRL_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [1:0]       usr_select,
    output logic [SIZE-1:0]  usr_parallelin,
    output logic             usr_left,
    output logic             usr_right,
    input  logic [SIZE-1:0]  usr_parallelout,
    output logic             busy,
    output logic             done,
    output logic [SIZE-1:0]  result
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SHR   = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_ROR   = 2'b11;
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SIZE-1:0]   result_q, result_d;
    logic [1:0]        sel_q, sel_d;
    logic [SIZE-1:0]   pin_q, pin_d;
    logic              left_q, left_d;
    logic              right_q, right_d;
    logic              abort_go;
    logic              rotate_c;

`ifdef USR_SEQ_CTRL_ABORT_EN
    logic              hit_q, hit_d;
    logic              aborted_q, aborted_d;
    assign abort_go = abort;
    assign aborted  = aborted_q;
`else
    assign abort_go = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        sel_d    = sel_q;
        pin_d    = pin_q;
        left_d   = left_q;
        right_d  = right_q;
`ifdef USR_SEQ_CTRL_ABORT_EN
        hit_d     = hit_q;
        aborted_d = aborted_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef USR_SEQ_CTRL_ABORT_EN
                    hit_d     = 1'b0;
                    aborted_d = 1'b0;
`endif
                    if (cmd_op == OP_LOAD) begin
                        sel_d   = SEL_LOAD;
                        pin_d   = cmd_data;
                        state_d = S_LOAD;
                    end else if (cmd_cnt != CNT_W'(0)) begin
                        cnt_d   = cmd_cnt;
                        sel_d   = (cmd_op == OP_ROR) ? SEL_SHR : cmd_op;
                        left_d  = (cmd_op == OP_SHL) && cmd_fill;
                        right_d = (cmd_op == OP_SHR) && cmd_fill;
                        state_d = S_SHIFT;
                    end else begin
                        sel_d   = SEL_HOLD;
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_LOAD: begin
                sel_d   = SEL_HOLD;
                state_d = S_CAPTURE;
            end
            S_SHIFT: begin
                // The edge that ends the final (or aborted) shift cycle drops to hold
                if ((cnt_q == CNT_W'(1)) || abort_go) begin
                    sel_d   = SEL_HOLD;
                    cnt_d   = CNT_W'(0);
                    left_d  = 1'b0;
                    right_d = 1'b0;
                    state_d = S_CAPTURE;
`ifdef USR_SEQ_CTRL_ABORT_EN
                    hit_d   = abort_go;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                result_d = usr_parallelout;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_DONE;
`ifdef USR_SEQ_CTRL_ABORT_EN
                aborted_d = hit_q;
`endif
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                sel_d   = SEL_HOLD;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_LOAD;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            sel_q    <= SEL_HOLD;
            pin_q    <= '0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
`ifdef USR_SEQ_CTRL_ABORT_EN
            hit_q     <= 1'b0;
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            sel_q    <= sel_d;
            pin_q    <= pin_d;
            left_q   <= left_d;
            right_q  <= right_d;
`ifdef USR_SEQ_CTRL_ABORT_EN
            hit_q     <= hit_d;
            aborted_q <= aborted_d;
`endif
        end
    end

    // Rotate feeds the current LSB straight back into the MSB serial input
    assign rotate_c       = (state_q == S_SHIFT) && (op_q == OP_ROR);
    assign usr_right      = rotate_c ? usr_parallelout[0] : right_q;
    assign usr_left       = left_q;
    assign usr_select     = sel_q;
    assign usr_parallelin = pin_q;
    assign cmd_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Randomized bench for usr_seq_ctrl: a transaction-level schedule model predicts every
// output cycle by cycle, with a behavioural USR closing the loop on usr_parallelout.
module tb_usr_seq_ctrl;

    localparam int unsigned SIZE  = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [SIZE-1:0]  cmd_data = '0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic             cmd_fill = 1'b0;
    logic [1:0]       usr_select;
    logic [SIZE-1:0]  usr_parallelin;
    logic             usr_left;
    logic             usr_right;
    logic [SIZE-1:0]  usr_parallelout;
    logic             busy;
    logic             done;
    logic [SIZE-1:0]  result;
`ifdef USR_SEQ_CTRL_ABORT_EN
    logic             abort = 1'b0;
    logic             aborted;
`endif

    always #5 clk = ~clk;

    usr_seq_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .cmd_cnt         (cmd_cnt),
        .cmd_fill        (cmd_fill),
`ifdef USR_SEQ_CTRL_ABORT_EN
        .abort           (abort),
        .aborted         (aborted),
`endif
        .usr_select      (usr_select),
        .usr_parallelin  (usr_parallelin),
        .usr_left        (usr_left),
        .usr_right       (usr_right),
        .usr_parallelout (usr_parallelout),
        .busy            (busy),
        .done            (done),
        .result          (result)
    );

    // Behavioural universal shift register driven by the DUT
    logic [SIZE-1:0] usr_q = '0;
    assign usr_parallelout = usr_q;
    always @(posedge clk) begin
        case (usr_select)
            2'b01:   usr_q <= {usr_right, usr_q[SIZE-1:1]};
            2'b10:   usr_q <= {usr_q[SIZE-2:0], usr_left};
            2'b11:   usr_q <= usr_parallelin;
            default: usr_q <= usr_q;
        endcase
    end

    // Expected outputs for one clock cycle
    typedef struct {
        logic [1:0]      sel;
        logic            busy, rdy, done;
        logic            shift, ld, lr, left, right, abt;
        logic [SIZE-1:0] pin, res, val;
    } exp_t;

    exp_t            cur;
    exp_t            q[$];
    logic [SIZE-1:0] model_val = '0;
    logic [SIZE-1:0] exp_res = '0;
    logic [SIZE-1:0] last_pin = '0;
    logic            exp_abt = 1'b0;
    logic            acc_flag = 1'b0;
    bit              chk_en = 1'b0;
    int              n_vec = 0;
    int              n_bad = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e.sel = 2'b00; e.busy = 1'b0; e.rdy = 1'b1; e.done = 1'b0;
        e.shift = 1'b0; e.ld = 1'b0; e.lr = 1'b0; e.left = 1'b0; e.right = 1'b0;
        e.abt = exp_abt; e.pin = last_pin; e.res = exp_res; e.val = model_val;
        return e;
    endfunction

    function automatic exp_t busy_e();
        exp_t e;
        e = idle_e();
        e.busy = 1'b1; e.rdy = 1'b0; e.abt = 1'b0;
        return e;
    endfunction

    // Expand one accepted command into its per-cycle expectation schedule
    task automatic build(input logic [1:0] op, input logic [SIZE-1:0] data,
                         input logic [CNT_W-1:0] cnt, input logic fill);
        exp_t e;
        logic [SIZE-1:0] v;
        v = model_val;
        if (op == 2'b00) begin
            last_pin = data;
            e = busy_e(); e.sel = 2'b11; e.ld = 1'b1; e.val = data;
            q.push_back(e);
            q.push_back(busy_e());
            v = data;
        end else begin
            for (int k = 0; k < int'(cnt); k++) begin
                e = busy_e();
                e.shift = 1'b1; e.lr = 1'b1;
                e.sel   = (op == 2'b11) ? 2'b01 : op;
                e.left  = (op == 2'b10) ? fill : 1'b0;
                e.right = (op == 2'b01) ? fill : ((op == 2'b11) ? v[0] : 1'b0);
                if (op == 2'b10) v = {v[SIZE-2:0], e.left};
                else             v = {e.right, v[SIZE-1:1]};
                e.val = v;
                q.push_back(e);
            end
            q.push_back(busy_e());
        end
        e = busy_e(); e.busy = 1'b0; e.done = 1'b1; e.res = v;
        q.push_back(e);
    endtask

    task automatic model_reset();
        q.delete();
        exp_res = '0; last_pin = '0; exp_abt = 1'b0;
        cur = idle_e();
    endtask

    task automatic model_edge();
        acc_flag = 1'b0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (cur.shift || cur.ld) model_val = cur.val;
`ifdef USR_SEQ_CTRL_ABORT_EN
        if (abort && cur.shift) begin
            exp_t t;
            while (q.size() > 0 && q[0].shift) q.delete(0);
            t = q[1]; t.res = cur.val; t.abt = 1'b1; q[1] = t;
        end
`endif
        if (cmd_valid && cur.rdy) begin
            acc_flag = 1'b1;
            exp_abt = 1'b0;
            build(cmd_op, cmd_data, cmd_cnt, cmd_fill);
        end
        if (q.size() > 0) begin
            cur = q[0];
            q.delete(0);
        end else begin
            cur = idle_e();
        end
        if (cur.done) begin
            exp_res = cur.res;
            exp_abt = cur.abt;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 8'(cmd_ready), 8'(cur.rdy));
            chk("busy", 8'(busy), 8'(cur.busy));
            chk("done", 8'(done), 8'(cur.done));
            chk("usr_select", 8'(usr_select), 8'(cur.sel));
            chk("usr_parallelin", 8'(usr_parallelin), 8'(cur.pin));
            chk("result", 8'(result), 8'(cur.res));
            if (cur.lr) begin
                chk("usr_left", 8'(usr_left), 8'(cur.left));
                chk("usr_right", 8'(usr_right), 8'(cur.right));
            end
`ifdef USR_SEQ_CTRL_ABORT_EN
            chk("aborted", 8'(aborted), 8'(cur.abt));
`endif
        end
    end

    task automatic send(input logic [1:0] op, input logic [SIZE-1:0] data,
                        input logic [CNT_W-1:0] cnt, input logic fill,
                        input bit scramble, output int lat);
        int w;
        cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_fill = fill; cmd_valid = 1'b1;
        w = 0;
        do begin step(); w++; end while (!acc_flag && w < 50);
        if (!acc_flag) chk("accept_timeout", 8'(0), 8'(1));
        cmd_valid = 1'b0;
        lat = 0;
        do begin
            if (scramble) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_data  = SIZE'($urandom_range(0, 15));
                cmd_cnt   = CNT_W'($urandom_range(0, 7));
                cmd_fill  = 1'($urandom_range(0, 1));
`ifdef USR_SEQ_CTRL_ABORT_EN
                abort     = ($urandom_range(0, 3) == 0);
`endif
            end
            step();
            lat++;
        end while (!done && lat < 20);
        cmd_valid = 1'b0;
`ifdef USR_SEQ_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        if (!done) chk("done_timeout", 8'(0), 8'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w, gap;
        bit seen;
        logic [1:0] op;
        logic [SIZE-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic fill;
        bit scr;

        cur = idle_e();
        repeat (3) step();
        chk_en = 1'b1;
        chk("rst_select", 8'(usr_select), 8'(0));
        chk("rst_ready", 8'(cmd_ready), 8'(1));
        chk("rst_result", 8'(result), 8'(0));
        chk("rst_left", 8'(usr_left), 8'(0));
        chk("rst_right", 8'(usr_right), 8'(0));
        rst = 1'b1;
        step();

        // Directed cases with hand-derived results and latencies
        send(2'b00, 4'b0110, 3'd0, 1'b0, 1'b0, lat);
        chk("load_lat", 8'(lat), 8'(2));
        chk("load_res", 8'(result), 8'(4'b0110));
        chk("load_model", 8'(exp_res), 8'(4'b0110));
        send(2'b01, 4'b0000, 3'd2, 1'b1, 1'b0, lat);
        chk("shr_lat", 8'(lat), 8'(3));
        chk("shr_res", 8'(result), 8'(4'b1101));
        chk("shr_model", 8'(exp_res), 8'(4'b1101));
        send(2'b00, 4'b1010, 3'd0, 1'b0, 1'b0, lat);
        send(2'b10, 4'b0000, 3'd3, 1'b1, 1'b0, lat);
        chk("shl_lat", 8'(lat), 8'(4));
        chk("shl_res", 8'(result), 8'(4'b0111));
        send(2'b00, 4'b0001, 3'd0, 1'b0, 1'b0, lat);
        send(2'b11, 4'b0000, 3'd1, 1'b0, 1'b0, lat);
        chk("ror1_lat", 8'(lat), 8'(2));
        chk("ror1_res", 8'(result), 8'(4'b1000));
        send(2'b00, 4'b1011, 3'd0, 1'b0, 1'b0, lat);
        send(2'b11, 4'b0000, 3'd4, 1'b0, 1'b0, lat);
        chk("ror4_res", 8'(result), 8'(4'b1011));
        chk("ror4_model", 8'(exp_res), 8'(4'b1011));
        send(2'b01, 4'b1111, 3'd0, 1'b1, 1'b1, lat);
        chk("cnt0_lat", 8'(lat), 8'(1));
        chk("cnt0_res", 8'(result), 8'(4'b1011));

        // Reset asserted in the middle of a 5-cycle shift
        step();
        cmd_op = 2'b01; cmd_data = '0; cmd_cnt = 3'd5; cmd_fill = 1'b1; cmd_valid = 1'b1;
        w = 0;
        do begin step(); w++; end while (!acc_flag && w < 50);
        cmd_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_select", 8'(usr_select), 8'(0));
        chk("midrst_pin", 8'(usr_parallelin), 8'(0));
        chk("midrst_right", 8'(usr_right), 8'(0));
        chk("midrst_busy", 8'(busy), 8'(0));
        chk("midrst_ready", 8'(cmd_ready), 8'(1));
        chk("midrst_result", 8'(result), 8'(0));
        seen = 1'b0;
        repeat (6) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("midrst_no_done", 8'(seen), 8'(0));
        rst = 1'b1;
        step();

`ifdef USR_SEQ_CTRL_ABORT_EN
        // Abort sampled on the second shift cycle: exactly two shifts happen
        send(2'b00, 4'b0110, 3'd0, 1'b0, 1'b0, lat);
        cmd_op = 2'b01; cmd_cnt = 3'd5; cmd_fill = 1'b0; cmd_valid = 1'b1;
        w = 0;
        do begin step(); w++; end while (!acc_flag && w < 50);
        cmd_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin step(); lat++; end
        chk("abort_lat", 8'(lat), 8'(3));
        chk("abort_res", 8'(result), 8'(4'b0001));
        chk("abort_flag", 8'(aborted), 8'(1));
`endif

        // Randomized command stream
        for (int i = 0; i < 150; i++) begin
            op   = 2'($urandom_range(0, 3));
            data = SIZE'($urandom_range(0, 15));
            cnt  = CNT_W'($urandom_range(0, 7));
            fill = 1'($urandom_range(0, 1));
            scr  = 1'($urandom_range(0, 1));
            send(op, data, cnt, fill, scr, lat);
            gap = $urandom_range(0, 2);
            repeat (gap) step();
        end
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
